// File: rtl/dwt97_lift_stream.sv
// Streaming CDF 9/7 forward DWT: one (even, odd) pair in, one (approx, detail) pair out per beat.
// Two lifting stages plus a scaling stage; frame edges use symmetric extension, each stage flushes its last element.
module dwt97_lift_stream #(
    parameter int DATA_W    = 16,
    parameter int GUARD     = 4,
    parameter int COEF_W    = 18,
    parameter int COEF_FRAC = 14,
    parameter int C_ALPHA   = -25987,
    parameter int C_BETA    = -868,
    parameter int C_GAMMA   = 14466,
    parameter int C_DELTA   = 7266,
    parameter int C_ZETA    = 18835,
    parameter int C_IZETA   = 14252
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_even,
    input  logic [DATA_W-1:0]         in_odd,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W+GUARD-1:0]   out_a,
    output logic [DATA_W+GUARD-1:0]   out_d,
    output logic                      out_last,
    output logic                      busy,
    output logic                      ovf
);
    localparam int OUT_W = DATA_W + GUARD;
    localparam int PW    = OUT_W + COEF_W;
    localparam logic signed [PW-1:0]     RND  = PW'(1) << (COEF_FRAC - 1);
    localparam logic signed [COEF_W-1:0] K_A  = COEF_W'(C_ALPHA);
    localparam logic signed [COEF_W-1:0] K_B  = COEF_W'(C_BETA);
    localparam logic signed [COEF_W-1:0] K_G  = COEF_W'(C_GAMMA);
    localparam logic signed [COEF_W-1:0] K_D  = COEF_W'(C_DELTA);
    localparam logic signed [COEF_W-1:0] K_Z  = COEF_W'(C_ZETA);
    localparam logic signed [COEF_W-1:0] K_IZ = COEF_W'(C_IZETA);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    // Results are {clamp flag, value}.
    function automatic logic [OUT_W:0] f_add(input logic signed [OUT_W-1:0] a,
                                             input logic signed [OUT_W-1:0] b);
        logic [OUT_W:0] s;
        s = {a[OUT_W-1], a} + {b[OUT_W-1], b};
        if (s[OUT_W] != s[OUT_W-1])
            return {1'b1, s[OUT_W], {(OUT_W-1){~s[OUT_W]}}};
        return {1'b0, s[OUT_W-1:0]};
    endfunction

    function automatic logic [OUT_W:0] f_mul(input logic signed [OUT_W-1:0]  v,
                                             input logic signed [COEF_W-1:0] c);
        logic signed [PW-1:0] p;
        logic signed [PW-1:0] r;
        p = PW'(v) * PW'(c);
        r = (p + RND) >>> COEF_FRAC;
        if ((r[PW-1:OUT_W-1] == '0) || (r[PW-1:OUT_W-1] == '1))
            return {1'b0, r[OUT_W-1:0]};
        return {1'b1, r[PW-1], {(OUT_W-1){~r[PW-1]}}};
    endfunction

    // base + c*(p + q), the shape shared by all four lifting steps
    function automatic logic [OUT_W:0] f_lift(input logic signed [OUT_W-1:0]  base,
                                              input logic signed [OUT_W-1:0]  p,
                                              input logic signed [OUT_W-1:0]  q,
                                              input logic signed [COEF_W-1:0] c);
        logic [OUT_W:0] s, m, r;
        s = f_add(p, q);
        m = f_mul(s[OUT_W-1:0], c);
        r = f_add(base, m[OUT_W-1:0]);
        return {s[OUT_W] | m[OUT_W] | r[OUT_W], r[OUT_W-1:0]};
    endfunction

    state_t r_state, w_state_nxt;
    logic   w_adv, w_acc;
    logic signed [OUT_W-1:0] w_ext_e, w_ext_o;

    logic                    r_in_v, r_in_last;
    logic signed [OUT_W-1:0] r_in_e, r_in_o;
    logic                    r_h_v, r_d1p_v, r_s1_fl;
    logic signed [OUT_W-1:0] r_h_e, r_h_o, r_d1p;
    logic                    r_a_v, r_a_last;
    logic signed [OUT_W-1:0] r_a_d1, r_a_s1;
    logic                    r_g_v, r_d2p_v, r_s2_fl;
    logic signed [OUT_W-1:0] r_g_d1, r_g_s1, r_d2p;
    logic                    r_b_v, r_b_last;
    logic signed [OUT_W-1:0] r_b_d2, r_b_s2;
    logic                    r_ov, r_olast, r_ovf;
    logic signed [OUT_W-1:0] r_oa, r_od;

    logic                    w_s1_do, w_s2_do, w_f_d1, w_f_s1, w_f_d2, w_f_s2, w_f_a, w_f_d, w_clamp;
    logic signed [OUT_W-1:0] w_s1_ne, w_d1, w_d1p, w_s1, w_s2_ns, w_d2, w_d2p, w_s2, w_a, w_d;

    assign w_adv     = !(r_ov && !out_ready);
    assign in_ready  = (r_state != S_FLUSH) && w_adv;
    assign w_acc     = in_valid && in_ready;
    assign w_ext_e   = OUT_W'($signed(in_even));
    assign w_ext_o   = OUT_W'($signed(in_odd));
    assign out_valid = r_ov;
    assign out_a     = r_oa;
    assign out_d     = r_od;
    assign out_last  = r_olast;
    assign busy      = (r_state != S_IDLE);
    assign ovf       = r_ovf;

    // A stage's flush beat reuses its own held sample as the right neighbour (mirror at the frame end).
    always_comb begin
        w_s1_ne          = r_s1_fl ? r_h_e : r_in_e;
        w_s1_do          = (r_in_v && r_h_v) || r_s1_fl;
        {w_f_d1, w_d1}   = f_lift(r_h_o, r_h_e, w_s1_ne, K_A);
        w_d1p            = r_d1p_v ? r_d1p : w_d1;
        {w_f_s1, w_s1}   = f_lift(r_h_e, w_d1p, w_d1, K_B);
        w_s2_ns          = r_s2_fl ? r_g_s1 : r_a_s1;
        w_s2_do          = (r_a_v && r_g_v) || r_s2_fl;
        {w_f_d2, w_d2}   = f_lift(r_g_d1, r_g_s1, w_s2_ns, K_G);
        w_d2p            = r_d2p_v ? r_d2p : w_d2;
        {w_f_s2, w_s2}   = f_lift(r_g_s1, w_d2p, w_d2, K_D);
        {w_f_a, w_a}     = f_mul(r_b_s2, K_Z);
        {w_f_d, w_d}     = f_mul(r_b_d2, K_IZ);
        w_clamp          = (w_s1_do && (w_f_d1 || w_f_s1)) || (w_s2_do && (w_f_d2 || w_f_s2))
                         || (r_b_v && (w_f_a || w_f_d));
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_acc) w_state_nxt = in_last ? S_FLUSH : S_RUN;
            S_RUN:   if (w_acc && in_last) w_state_nxt = S_FLUSH;
            S_FLUSH: if (r_ov && out_ready && r_olast) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_in_v  <= 1'b0; r_in_last <= 1'b0; r_in_e <= '0; r_in_o <= '0;
            r_h_v   <= 1'b0; r_d1p_v <= 1'b0; r_s1_fl <= 1'b0; r_h_e <= '0; r_h_o <= '0; r_d1p <= '0;
            r_a_v   <= 1'b0; r_a_last <= 1'b0; r_a_d1 <= '0; r_a_s1 <= '0;
            r_g_v   <= 1'b0; r_d2p_v <= 1'b0; r_s2_fl <= 1'b0; r_g_d1 <= '0; r_g_s1 <= '0; r_d2p <= '0;
            r_b_v   <= 1'b0; r_b_last <= 1'b0; r_b_d2 <= '0; r_b_s2 <= '0;
            r_ov    <= 1'b0; r_olast <= 1'b0; r_oa <= '0; r_od <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_adv) begin
                r_in_v <= w_acc;
                if (w_acc) begin
                    r_in_e    <= w_ext_e;
                    r_in_o    <= w_ext_o;
                    r_in_last <= in_last;
                end
                r_a_v    <= w_s1_do;
                r_a_d1   <= w_d1;
                r_a_s1   <= w_s1;
                r_a_last <= r_s1_fl;
                if (r_in_v) begin
                    r_h_v   <= 1'b1;
                    r_h_e   <= r_in_e;
                    r_h_o   <= r_in_o;
                    r_s1_fl <= r_in_last;
                end
                if (w_s1_do) begin
                    r_d1p   <= w_d1;
                    r_d1p_v <= 1'b1;
                end
                if (r_s1_fl) begin
                    r_h_v   <= 1'b0;
                    r_d1p_v <= 1'b0;
                    r_s1_fl <= 1'b0;
                end
                r_b_v    <= w_s2_do;
                r_b_d2   <= w_d2;
                r_b_s2   <= w_s2;
                r_b_last <= r_s2_fl;
                if (r_a_v) begin
                    r_g_v   <= 1'b1;
                    r_g_d1  <= r_a_d1;
                    r_g_s1  <= r_a_s1;
                    r_s2_fl <= r_a_last;
                end
                if (w_s2_do) begin
                    r_d2p   <= w_d2;
                    r_d2p_v <= 1'b1;
                end
                if (r_s2_fl) begin
                    r_g_v   <= 1'b0;
                    r_d2p_v <= 1'b0;
                    r_s2_fl <= 1'b0;
                end
                r_ov    <= r_b_v;
                r_olast <= r_b_v && r_b_last;
                if (r_b_v) begin
                    r_oa <= w_a;
                    r_od <= w_d;
                end
                r_ovf <= r_ovf || w_clamp;
            end
        end
    end
endmodule

// File: tb/tb_dwt97_lift_stream.sv
// Self-checking bench for dwt97_lift_stream: randomized frames against an array-based lifting model.
// A second instance with no guard bits shares the stimulus so saturation is reachable.
module tb_dwt97_lift_stream;
    localparam int OW  = 20;
    localparam int SOW = 16;
    localparam longint CA = -25987, CB = -868, CG = 14466, CD = 7266, CZ = 18835, CIZ = 14252;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [15:0] in_even = '0, in_odd = '0;
    logic in_ready, out_valid, out_last, busy, ovf;
    logic [OW-1:0] out_a, out_d;
    logic s_in_ready, s_out_valid, s_out_last, s_busy, s_ovf;
    logic [SOW-1:0] s_out_a, s_out_d;

    int n_checks = 0, n_fail = 0, cyc = 0;
    int tx_e[$], tx_o[$], got_a[$], got_d[$], got_sa[$], got_sd[$], acc_cyc[$], out_cyc[$];
    bit got_last[$];
    int hold_err, last_hs_edge;
    bit timed_out, m_of;
    longint ra[64], rd[64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dwt97_lift_stream u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_even(in_even), .in_odd(in_odd), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_d(out_d),
        .out_last(out_last), .busy(busy), .ovf(ovf));

    dwt97_lift_stream #(.GUARD(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_even(in_even), .in_odd(in_odd), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_a(s_out_a), .out_d(s_out_d),
        .out_last(s_out_last), .busy(s_busy), .ovf(s_ovf));

    function automatic longint satw(input longint v, input int w);
        longint mx, mn;
        mx = (longint'(1) << (w - 1)) - 1;
        mn = -mx - 1;
        if (v > mx) begin m_of = 1'b1; return mx; end
        if (v < mn) begin m_of = 1'b1; return mn; end
        return v;
    endfunction

    function automatic longint mulc(input longint v, input longint c, input int w);
        return satw((v * c + 8192) >>> 14, w);
    endfunction

    function automatic longint lift(input longint b, input longint p, input longint q,
                                    input longint c, input int w);
        return satw(b + mulc(satw(p + q, w), c, w), w);
    endfunction

    // Equations evaluated over the whole frame; edge terms mirrored explicitly.
    function automatic void ref_frame(input int P, input int w);
        longint d1[64], s1[64], d2[64], s2[64];
        m_of = 1'b0;
        for (int n = 0; n < P; n++)
            d1[n] = lift(tx_o[n], tx_e[n], (n == P-1) ? tx_e[n] : tx_e[n+1], CA, w);
        for (int n = 0; n < P; n++)
            s1[n] = lift(tx_e[n], (n == 0) ? d1[0] : d1[n-1], d1[n], CB, w);
        for (int n = 0; n < P; n++)
            d2[n] = lift(d1[n], s1[n], (n == P-1) ? s1[n] : s1[n+1], CG, w);
        for (int n = 0; n < P; n++)
            s2[n] = lift(s1[n], (n == 0) ? d2[0] : d2[n-1], d2[n], CD, w);
        for (int n = 0; n < P; n++) begin
            ra[n] = mulc(s2[n], CZ, w);
            rd[n] = mulc(d2[n], CIZ, w);
        end
    endfunction

    task automatic drive_frame(input int P, input int ready_pct);
        int idx = 0;
        bit done = 1'b0, pst = 1'b0, pl = 1'b0;
        logic [OW-1:0] pa = '0, pd = '0;
        got_a.delete(); got_d.delete(); got_sa.delete(); got_sd.delete(); got_last.delete();
        acc_cyc.delete(); out_cyc.delete();
        hold_err = 0; timed_out = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            in_valid = (idx < P);
            in_last  = (idx == P-1);
            if (idx < P) begin
                in_even = 16'(tx_e[idx]);
                in_odd  = 16'(tx_o[idx]);
            end
            out_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (pst && (out_valid !== 1'b1 || out_a !== pa || out_d !== pd || out_last !== pl))
                hold_err++;
            pst = out_valid && !out_ready; pa = out_a; pd = out_d; pl = out_last;
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc + 1);
                idx++;
            end
            if (out_valid && out_ready) begin
                got_a.push_back(int'($signed(out_a)));
                got_d.push_back(int'($signed(out_d)));
                got_sa.push_back(int'($signed(s_out_a)));
                got_sd.push_back(int'($signed(s_out_d)));
                got_last.push_back(out_last);
                out_cyc.push_back(cyc);
                if (out_last) begin
                    done = 1'b1;
                    last_hs_edge = cyc + 1;
                end
            end
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        if (!done) timed_out = 1'b1;
    endtask

    task automatic fill_dc(input int P, input int v);
        tx_e.delete(); tx_o.delete();
        for (int i = 0; i < P; i++) begin tx_e.push_back(v); tx_o.push_back(v); end
    endtask

    task automatic fill_rand(input int P);
        tx_e.delete(); tx_o.delete();
        for (int i = 0; i < P; i++) begin
            tx_e.push_back(int'($urandom_range(65535)) - 32768);
            tx_o.push_back(int'($urandom_range(65535)) - 32768);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL reset_busy_ovf: got %b%b want 00", busy, ovf); end
        n_checks++; if (out_a !== '0 || out_d !== '0 || out_last !== 1'b0) begin n_fail++; $display("FAIL reset_data: got %h %h %b want 0 0 0", out_a, out_d, out_last); end
        rst_n = 1'b1;
    endtask

    task automatic test_dc;
        fill_dc(4, 100);
        drive_frame(4, 100);
        n_checks++; if (timed_out !== 1'b0 || got_a.size() != 4) begin n_fail++; $display("FAIL dc_count: got %0d want 4 (timeout %b)", got_a.size(), timed_out); end
        for (int i = 0; i < got_a.size(); i++) begin
            n_checks++;
            if (got_a[i] < 140 || got_a[i] > 142 || got_d[i] < -1 || got_d[i] > 1 || got_last[i] !== (i == 3)) begin
                n_fail++; $display("FAIL dc_pair%0d: got a=%0d d=%0d last=%b want a=141+-1 d=0+-1 last=%b", i, got_a[i], got_d[i], got_last[i], i == 3);
            end
        end
    endtask

    task automatic test_single;
        fill_dc(1, 100);
        drive_frame(1, 100);
        n_checks++;
        if (timed_out !== 1'b0 || got_a.size() != 1 || got_a[0] < 140 || got_a[0] > 142 || got_d[0] < -1 || got_d[0] > 1 || got_last[0] !== 1'b1) begin
            n_fail++; $display("FAIL single_pair: got n=%0d a=%0d d=%0d want n=1 a=141+-1 d=0+-1 last=1", got_a.size(), got_a.size() ? got_a[0] : 0, got_d.size() ? got_d[0] : 0);
        end
        @(negedge clk); #1;
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got ready=%b busy=%b want 1 0", in_ready, busy); end
    endtask

    task automatic test_latency;
        int base = int'($urandom_range(2000)) - 1000;
        tx_e.delete(); tx_o.delete();
        for (int i = 0; i < 8; i++) begin tx_e.push_back(base + 200*i); tx_o.push_back(base + 200*i + 100); end
        ref_frame(8, OW);
        drive_frame(8, 100);
        n_checks++; if (timed_out !== 1'b0 || got_a.size() != 8) begin n_fail++; $display("FAIL lat_count: got %0d want 8", got_a.size()); end
        else begin
            n_checks++; if (out_cyc[0] != acc_cyc[2] + 3) begin n_fail++; $display("FAIL lat_first: got cycle %0d want %0d", out_cyc[0], acc_cyc[2] + 3); end
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (got_a[i] != ra[i] || got_d[i] != rd[i] || got_last[i] !== (i == 7)) begin
                    n_fail++; $display("FAIL lat_pair%0d: got %0d %0d %b want %0d %0d %b", i, got_a[i], got_d[i], got_last[i], ra[i], rd[i], i == 7);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        fill_rand(16);
        drive_frame(16, 50);
        n_checks++; if (timed_out !== 1'b0 || got_a.size() != 16) begin n_fail++; $display("FAIL bp_count: got %0d want 16", got_a.size()); end
        n_checks++; if (hold_err != 0) begin n_fail++; $display("FAIL bp_hold: got %0d changes while stalled want 0", hold_err); end
        ref_frame(16, OW);
        for (int i = 0; i < got_a.size() && i < 16; i++) begin
            n_checks++;
            if (got_a[i] != ra[i] || got_d[i] != rd[i] || got_last[i] !== (i == 15)) begin
                n_fail++; $display("FAIL bp_pair%0d: got %0d %0d %b want %0d %0d %b", i, got_a[i], got_d[i], got_last[i], ra[i], rd[i], i == 15);
            end
        end
        ref_frame(16, SOW);
        for (int i = 0; i < got_sa.size() && i < 16; i++) begin
            n_checks++;
            if (got_sa[i] != ra[i] || got_sd[i] != rd[i]) begin
                n_fail++; $display("FAIL bp_narrow%0d: got %0d %0d want %0d %0d", i, got_sa[i], got_sd[i], ra[i], rd[i]);
            end
        end
    endtask

    task automatic test_saturation;
        bit wide_of;
        tx_e.delete(); tx_o.delete();
        for (int i = 0; i < 8; i++) begin tx_e.push_back(32767); tx_o.push_back(-32768); end
        ref_frame(8, OW);
        wide_of = m_of;
        drive_frame(8, 100);
        n_checks++; if (timed_out !== 1'b0 || got_sa.size() != 8) begin n_fail++; $display("FAIL sat_count: got %0d want 8", got_sa.size()); end
        n_checks++; if (ovf !== wide_of) begin n_fail++; $display("FAIL sat_wide_ovf: got %b want %b", ovf, wide_of); end
        for (int i = 0; i < got_a.size() && i < 8; i++) begin
            n_checks++;
            if (got_a[i] != ra[i] || got_d[i] != rd[i]) begin
                n_fail++; $display("FAIL sat_wide%0d: got %0d %0d want %0d %0d", i, got_a[i], got_d[i], ra[i], rd[i]);
            end
        end
        ref_frame(8, SOW);
        for (int i = 0; i < got_sa.size() && i < 8; i++) begin
            n_checks++;
            if (got_sa[i] != 32767 || got_sa[i] != ra[i] || got_sd[i] != rd[i]) begin
                n_fail++; $display("FAIL sat_narrow%0d: got %0d %0d want 32767/%0d %0d", i, got_sa[i], got_sd[i], ra[i], rd[i]);
            end
        end
        n_checks++; if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b want 1", s_ovf); end
        fill_dc(4, 100);
        drive_frame(4, 100);
        n_checks++; if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf_sticky: got %b want 1", s_ovf); end
    endtask

    task automatic test_reset_mid;
        int idx = 0, n_out = 0;
        bit acc3 = 1'b0;
        fill_rand(8);
        for (int k = 0; k < 200 && !acc3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_even = 16'(tx_e[idx]); in_odd = 16'(tx_o[idx]);
            in_last = (idx == 7); out_ready = 1'b1;
            #1;
            if (out_valid) n_out++;
            if (in_valid && in_ready) begin
                if (idx == 3) acc3 = 1'b1;
                idx++;
            end
        end
        n_checks++; if (acc3 !== 1'b1) begin n_fail++; $display("FAIL mid_accept: got %0d pairs want 4", idx); end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; rst_n = 1'b0;
        #1; if (out_valid) n_out++;
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_state: got v=%b r=%b b=%b want 0 1 0", out_valid, in_ready, busy); end
        n_checks++; if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL mid_ovf_clear: got %b want 0", s_ovf); end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin @(negedge clk); #1; if (out_valid) n_out++; end
        n_checks++; if (n_out != 0) begin n_fail++; $display("FAIL mid_no_output: got %0d outputs want 0", n_out); end
    endtask

    task automatic test_back_to_back;
        int hs1, na;
        fill_dc(4, 100);
        drive_frame(4, 100);
        hs1 = last_hs_edge;
        na = got_a.size();
        n_checks++; if (timed_out !== 1'b0 || na != 4 || got_a[na-1] < 140 || got_a[na-1] > 142) begin n_fail++; $display("FAIL b2b_frame1: got n=%0d a=%0d want 4 141+-1", na, na ? got_a[na-1] : 0); end
        fill_dc(4, 50);
        drive_frame(4, 100);
        n_checks++; if (acc_cyc.size() == 0 || acc_cyc[0] != hs1 + 1) begin n_fail++; $display("FAIL b2b_gap: got first accept %0d want %0d", acc_cyc.size() ? acc_cyc[0] : -1, hs1 + 1); end
        n_checks++; if (timed_out !== 1'b0 || got_a.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", got_a.size()); end
        for (int i = 0; i < got_a.size(); i++) begin
            n_checks++;
            if (got_a[i] < 70 || got_a[i] > 72 || got_d[i] < -1 || got_d[i] > 1) begin
                n_fail++; $display("FAIL b2b_pair%0d: got a=%0d d=%0d want 71+-1 0+-1", i, got_a[i], got_d[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dc();
        test_single();
        test_latency();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
